conv3x3_ctrl: RTL and testbench

//  Sequencer for the 3x3 convolution datapath (9 pixel registers r0..r8, 9 coefficients s0..s8,

---
 rtl/conv_pkg.sv | 23 ++
 rtl/conv_tap_counter.sv | 42 ++++
 rtl/conv3x3_ctrl.sv | 143 ++++++++++++++
 tb/tb_conv3x3_ctrl.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared types and constants for the 3x3 convolution sequencer.
//   state_e  : controller FSM encoding (3 bits)
//   NUM_TAPS : taps per window (fixed at 9)
//   LAST_TAP : final tap index
//   SEL_W    : width of tap index and ALU selects
//   CNT_W    : width of the completed-window counter
package conv_pkg;

    localparam int unsigned NUM_TAPS = 9;
    localparam int unsigned SEL_W    = 4;
    localparam int unsigned CNT_W    = 16;

    localparam logic [SEL_W-1:0] LAST_TAP = SEL_W'(NUM_TAPS - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        LOAD  = 3'd2,
        MAC   = 3'd3,
        DONE  = 3'd4
    } state_e;

endpackage

// File: rtl/conv_tap_counter.sv
// Tap index counter shared by the pixel-load and MAC phases.
//   clk, resetn : clock, synchronous active-low reset
//   clr         : force index to 0 (wins over en)
//   en          : advance index by one
//   idx         : current tap index
//   last_tap    : index is at the final tap
module conv_tap_counter
    import conv_pkg::*;
(
    input  logic             clk,
    input  logic             resetn,
    input  logic             clr,
    input  logic             en,
    output logic [SEL_W-1:0] idx,
    output logic             last_tap
);

    logic [SEL_W-1:0] idx_q;
    logic [SEL_W-1:0] idx_d;

    // Next index: clear has priority so the final step of a phase wraps to 0.
    always_comb begin
        idx_d = idx_q;
        if (clr) begin
            idx_d = '0;
        end else if (en) begin
            idx_d = idx_q + SEL_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

    assign idx      = idx_q;
    assign last_tap = (idx_q == LAST_TAP);

endmodule

// File: rtl/conv3x3_ctrl.sv
// Sequencer for the 3x3 convolution datapath: clears the accumulator, loads
// nine pixels from a valid/ready stream, runs nine MAC cycles, then holds the
// result on a valid/ready handshake.
//   clk, resetn            : clock, synchronous active-low reset
//   start                  : request one window (honoured in IDLE, or DONE with res_ready)
//   pix_valid / pix_ready  : pixel stream handshake
//   res_valid / res_ready  : result handshake
//   acc_clr                : one-cycle accumulator clear
//   ld_0..ld_8             : pixel register load enables
//   ld_r                   : accumulate enable
//   alu_select_a/b         : pixel / coefficient select during MAC
//   busy                   : controller not in IDLE
//   win_count              : number of results accepted
module conv3x3_ctrl
    import conv_pkg::*;
(
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             pix_valid,
    output logic             pix_ready,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             acc_clr,
    output logic             ld_0,
    output logic             ld_1,
    output logic             ld_2,
    output logic             ld_3,
    output logic             ld_4,
    output logic             ld_5,
    output logic             ld_6,
    output logic             ld_7,
    output logic             ld_8,
    output logic             ld_r,
    output logic [SEL_W-1:0] alu_select_a,
    output logic [SEL_W-1:0] alu_select_b,
    output logic             busy,
    output logic [CNT_W-1:0] win_count
);

    state_e              state_q;
    state_e              state_d;
    logic [CNT_W-1:0]    win_count_q;
    logic [CNT_W-1:0]    win_count_d;
    logic [NUM_TAPS-1:0] ld_vec;
    logic [SEL_W-1:0]    sel;
    logic [SEL_W-1:0]    idx;
    logic                last_tap;
    logic                cnt_clr;
    logic                cnt_en;

    conv_tap_counter u_tap_counter (
        .clk      (clk),
        .resetn   (resetn),
        .clr      (cnt_clr),
        .en       (cnt_en),
        .idx      (idx),
        .last_tap (last_tap)
    );

    // Next-state and output decode; all strobes are mutually exclusive by state.
    always_comb begin
        state_d     = state_q;
        win_count_d = win_count_q;
        pix_ready   = 1'b0;
        res_valid   = 1'b0;
        acc_clr     = 1'b0;
        ld_vec      = '0;
        ld_r        = 1'b0;
        sel         = '0;
        busy        = 1'b1;
        cnt_clr     = 1'b0;
        cnt_en      = 1'b0;

        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                acc_clr = 1'b1;
                cnt_clr = 1'b1;
                state_d = LOAD;
            end
            LOAD: begin
                pix_ready = 1'b1;
                if (pix_valid) begin
                    ld_vec = NUM_TAPS'(1) << idx;
                    cnt_en = 1'b1;
                    if (last_tap) begin
                        cnt_clr = 1'b1;
                        state_d = MAC;
                    end
                end
            end
            MAC: begin
                ld_r   = 1'b1;
                sel    = idx;
                cnt_en = 1'b1;
                if (last_tap) begin
                    cnt_clr = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    win_count_d = win_count_q + CNT_W'(1);
                    state_d     = start ? CLEAR : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= IDLE;
            win_count_q <= '0;
        end else begin
            state_q     <= state_d;
            win_count_q <= win_count_d;
        end
    end

    assign ld_0         = ld_vec[0];
    assign ld_1         = ld_vec[1];
    assign ld_2         = ld_vec[2];
    assign ld_3         = ld_vec[3];
    assign ld_4         = ld_vec[4];
    assign ld_5         = ld_vec[5];
    assign ld_6         = ld_vec[6];
    assign ld_7         = ld_vec[7];
    assign ld_8         = ld_vec[8];
    assign alu_select_a = sel;
    assign alu_select_b = sel;
    assign win_count    = win_count_q;

endmodule

// File: tb/tb_conv3x3_ctrl.sv
// Bench for conv3x3_ctrl with a behavioural 8-bit MAC datapath and a result scoreboard.
module tb_conv3x3_ctrl;
    import conv_pkg::*;

    logic             clk = 1'b0;
    logic             resetn;
    logic             start;
    logic             pix_valid;
    logic             pix_ready;
    logic             res_valid;
    logic             res_ready;
    logic             acc_clr;
    logic             ld_0, ld_1, ld_2, ld_3, ld_4, ld_5, ld_6, ld_7, ld_8;
    logic             ld_r;
    logic [SEL_W-1:0] sel_a;
    logic [SEL_W-1:0] sel_b;
    logic             busy;
    logic [CNT_W-1:0] win_count;

    conv3x3_ctrl dut (
        .clk          (clk),
        .resetn       (resetn),
        .start        (start),
        .pix_valid    (pix_valid),
        .pix_ready    (pix_ready),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .acc_clr      (acc_clr),
        .ld_0         (ld_0),
        .ld_1         (ld_1),
        .ld_2         (ld_2),
        .ld_3         (ld_3),
        .ld_4         (ld_4),
        .ld_5         (ld_5),
        .ld_6         (ld_6),
        .ld_7         (ld_7),
        .ld_8         (ld_8),
        .ld_r         (ld_r),
        .alu_select_a (sel_a),
        .alu_select_b (sel_b),
        .busy         (busy),
        .win_count    (win_count)
    );

    always #5 clk = ~clk;

    wire [8:0] ld_vec = {ld_8, ld_7, ld_6, ld_5, ld_4, ld_3, ld_2, ld_1, ld_0};

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int t_start = 0;
    int mac_n  = 0;
    logic [7:0] exp_q[$];

    // Behavioural datapath: pixel regs, coefficients, truncating 8-bit accumulator.
    logic [7:0] data_in;
    logic [7:0] r[9];
    logic [7:0] s[9];
    logic [7:0] data_result = 8'd0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (acc_clr) data_result <= 8'd0;
        for (int k = 0; k < 9; k++) begin
            if (ld_vec[k]) r[k] <= data_in;
        end
        if (ld_r && int'(sel_a) < 9 && int'(sel_b) < 9)
            data_result <= data_result + r[int'(sel_a)] * s[int'(sel_b)];
    end

    function automatic void chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Monitor: strobe exclusivity, MAC select order, scoreboard pop on result handshake.
    always @(negedge clk) begin
        if (resetn) begin
            chk("strobe_exclusive", int'($countones({acc_clr, ld_vec, ld_r}) <= 1), 1);
            if (!ld_r) chk("sel_zero_outside_mac", int'({sel_a, sel_b}), 0);
            if (acc_clr) mac_n = 0;
            if (ld_r) begin
                chk("mac_sel_a", int'(sel_a), mac_n);
                chk("mac_sel_b", int'(sel_b), mac_n);
                mac_n++;
            end
            if (res_valid && res_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL result_unexpected: got %0d expected none", data_result);
                end else begin
                    chk("result", int'(data_result), int'(exp_q.pop_front()));
                end
            end
        end
    end

    task automatic check_quiet(input string tag);
        chk({tag, "_pix_ready"}, int'(pix_ready), 0);
        chk({tag, "_res_valid"}, int'(res_valid), 0);
        chk({tag, "_acc_clr"},   int'(acc_clr), 0);
        chk({tag, "_ld_vec"},    int'(ld_vec), 0);
        chk({tag, "_ld_r"},      int'(ld_r), 0);
        chk({tag, "_sel"},       int'({sel_a, sel_b}), 0);
        chk({tag, "_busy"},      int'(busy), 0);
        chk({tag, "_win_count"}, int'(win_count), 0);
    endtask

    task automatic do_start(input bit push, input logic [7:0] exp);
        @(posedge clk); #1;
        start = 1'b1;
        if (push) exp_q.push_back(exp);
        @(posedge clk); #1;
        start   = 1'b0;
        t_start = cyc;
    endtask

    task automatic feed(input logic [7:0] pix[9], input int gap_after, input int gap_len, input bit spur);
        int   k = 0;
        int   gap = 0;
        int   guard = 0;
        logic acc;
        pix_valid = 1'b1;
        data_in   = pix[0];
        while (k < 9 && guard < 200) begin
            @(negedge clk);
            guard++;
            acc = pix_valid && pix_ready;
            if (acc) chk("ld_onehot", int'(ld_vec), 1 << k);
            if (gap > 0) begin
                chk("gap_no_ld", int'(ld_vec), 0);
                chk("gap_pix_ready", int'(pix_ready), 1);
            end
            @(posedge clk); #1;
            start = 1'b0;
            if (acc) begin
                k++;
                if (k < 9) begin
                    data_in = pix[k];
                    if (k == gap_after && gap_len > 0) begin
                        pix_valid = 1'b0;
                        gap       = gap_len;
                    end
                    if (spur && k == 3) start = 1'b1;
                end else begin
                    pix_valid = 1'b0;
                end
            end else if (gap > 0) begin
                gap--;
                if (gap == 0) pix_valid = 1'b1;
            end
        end
        if (k < 9) chk("feed_timeout", k, 9);
    endtask

    task automatic wait_result(input int exp_lat, input bit spur);
        int guard = 0;
        do begin
            @(negedge clk);
            guard++;
            start = (spur && ld_r && sel_a == SEL_W'(3));
        end while (!res_valid && guard < 100);
        start = 1'b0;
        if (!res_valid) begin
            chk("res_valid_timeout", 0, 1);
        end else begin
            chk("latency", cyc - t_start, exp_lat);
            chk("mac_cycles", mac_n, 9);
        end
    endtask

    task automatic accept(input int hold, input bit b2b, input logic [7:0] exp2);
        logic [7:0] held;
        held = data_result;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("hold_res_valid", int'(res_valid), 1);
            chk("hold_result", int'(data_result), int'(held));
            chk("hold_no_ld_r", int'(ld_r), 0);
        end
        @(posedge clk); #1;
        res_ready = 1'b1;
        if (b2b) begin
            start = 1'b1;
            exp_q.push_back(exp2);
        end
        @(posedge clk); #1;
        res_ready = 1'b0;
        start     = 1'b0;
        t_start   = cyc;
        @(negedge clk);
        chk("post_res_valid", int'(res_valid), 0);
        if (b2b) chk("b2b_acc_clr", int'(acc_clr), 1);
        else     chk("post_busy", int'(busy), 0);
    endtask

    logic [7:0] p_seq[9];
    logic [7:0] p_200[9];
    logic [7:0] p_zero[9];

    initial begin
        int guard;
        resetn    = 1'b0;
        start     = 1'b0;
        pix_valid = 1'b0;
        res_ready = 1'b0;
        data_in   = 8'd0;
        for (int k = 0; k < 9; k++) begin
            s[k]      = 8'd1;
            p_seq[k]  = 8'(k + 1);
            p_200[k]  = 8'd200;
            p_zero[k] = 8'd0;
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_quiet("reset");
        @(posedge clk); #1;
        resetn = 1'b1;

        // Abort in MAC at tap 4.
        do_start(1'b0, 8'd0);
        feed(p_seq, -1, 0, 1'b0);
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!(ld_r && sel_a == SEL_W'(4)) && guard < 50);
        if (guard >= 50) chk("abort_reach_tap4", 0, 1);
        resetn = 1'b0;
        @(negedge clk);
        check_quiet("abort");
        @(posedge clk); #1;
        resetn = 1'b1;

        // Pixels 1..9, continuous stream.
        do_start(1'b1, 8'd45);
        feed(p_seq, -1, 0, 1'b0);
        wait_result(19, 1'b0);
        accept(0, 1'b0, 8'd0);
        chk("win_count_1", int'(win_count), 1);

        // Three-cycle stall after the fourth pixel.
        do_start(1'b1, 8'd45);
        feed(p_seq, 4, 3, 1'b0);
        wait_result(22, 1'b0);
        accept(0, 1'b0, 8'd0);
        chk("win_count_2", int'(win_count), 2);

        // Nine pixels of 200: 1800 mod 256.
        do_start(1'b1, 8'd8);
        feed(p_200, -1, 0, 1'b0);
        wait_result(19, 1'b0);
        accept(0, 1'b0, 8'd0);
        chk("win_count_3", int'(win_count), 3);

        // Held result, then back-to-back window of zeros.
        do_start(1'b1, 8'd45);
        feed(p_seq, -1, 0, 1'b0);
        wait_result(19, 1'b0);
        accept(5, 1'b1, 8'd0);
        chk("win_count_4", int'(win_count), 4);
        feed(p_zero, -1, 0, 1'b0);
        wait_result(19, 1'b0);
        accept(0, 1'b0, 8'd0);
        chk("win_count_5", int'(win_count), 5);

        // Fresh reset, then stray starts during LOAD and MAC.
        @(posedge clk); #1;
        resetn = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        do_start(1'b1, 8'd45);
        feed(p_seq, -1, 0, 1'b1);
        wait_result(19, 1'b1);
        accept(0, 1'b0, 8'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stay_idle_busy", int'(busy), 0);
        end
        chk("win_count_single", int'(win_count), 1);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
